tri_bbox_scanner: RTL and testbench

- Sits between the 3D-to-2D projection stage and the 2D fill/pixel-write stage.
- Accepts one screen-space triangle per handshake and computes its bounding box, clipped to the frame.
- Emits every pixel coordinate inside the clipped box in raster order with valid/ready backpressure, so downstream fill and pixel-write logic only visits candidate pixels instead of sweeping the whole frame.

---
 rtl/tri_bbox_scanner.sv | 155 +++++++++++++++
 tb/tb_tri_bbox_scanner.sv | 411 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tri_bbox_scanner.sv
// Triangle bounding-box scanner: clips a screen-space triangle's bounding box to the frame
// and streams every candidate pixel coordinate in raster order under valid/ready flow control.
module tri_bbox_scanner #(
  parameter int unsigned FRAME_WIDTH  = 512,
  parameter int unsigned FRAME_HEIGHT = 384,
  parameter int unsigned COORD_BITS   = 16,
  parameter int unsigned COLOR_BITS   = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         tri_valid,
  output logic                         tri_ready,
  input  logic signed [COORD_BITS-1:0] tri_x0,
  input  logic signed [COORD_BITS-1:0] tri_y0,
  input  logic signed [COORD_BITS-1:0] tri_x1,
  input  logic signed [COORD_BITS-1:0] tri_y1,
  input  logic signed [COORD_BITS-1:0] tri_x2,
  input  logic signed [COORD_BITS-1:0] tri_y2,
  input  logic [COLOR_BITS-1:0]        tri_color,
  output logic                         pix_valid,
  input  logic                         pix_ready,
  output logic [COORD_BITS-1:0]        pix_x,
  output logic [COORD_BITS-1:0]        pix_y,
  output logic [COLOR_BITS-1:0]        pix_color,
  output logic                         pix_last,
  output logic                         tri_done,
  output logic                         busy
);

  localparam logic signed [COORD_BITS-1:0] Zero = '0;
  localparam logic signed [COORD_BITS-1:0] XLim = COORD_BITS'(FRAME_WIDTH - 1);
  localparam logic signed [COORD_BITS-1:0] YLim = COORD_BITS'(FRAME_HEIGHT - 1);

  typedef enum logic [1:0] {StIdle, StSetup, StScan, StFinish} state_e;

  state_e state_q, state_d;

  logic signed [COORD_BITS-1:0] x0_q, y0_q, x1_q, y1_q, x2_q, y2_q;
  logic [COLOR_BITS-1:0]        color_q;
  logic [COORD_BITS-1:0]        xmin_q, xmax_q, ymax_q;
  logic [COORD_BITS-1:0]        pix_x_q, pix_y_q;

  logic signed [COORD_BITS-1:0] xmin_c, xmax_c, ymin_c, ymax_c;
  logic [COORD_BITS-1:0]        xlo, xhi, ylo, yhi;
  logic                         box_empty, at_row_end, at_last, pix_fire;

  always_comb begin
    xmin_c = x0_q;
    xmax_c = x0_q;
    ymin_c = y0_q;
    ymax_c = y0_q;
    if (x1_q < xmin_c) xmin_c = x1_q;
    if (x2_q < xmin_c) xmin_c = x2_q;
    if (x1_q > xmax_c) xmax_c = x1_q;
    if (x2_q > xmax_c) xmax_c = x2_q;
    if (y1_q < ymin_c) ymin_c = y1_q;
    if (y2_q < ymin_c) ymin_c = y2_q;
    if (y1_q > ymax_c) ymax_c = y1_q;
    if (y2_q > ymax_c) ymax_c = y2_q;
  end

  // Emptiness is judged on the unclipped box; clipping alone would fold it onto an edge.
  assign box_empty = (xmax_c < Zero) || (xmin_c > XLim) || (ymax_c < Zero) || (ymin_c > YLim);
  assign xlo = (xmin_c < Zero) ? '0 : xmin_c;
  assign xhi = (xmax_c > XLim) ? XLim : xmax_c;
  assign ylo = (ymin_c < Zero) ? '0 : ymin_c;
  assign yhi = (ymax_c > YLim) ? YLim : ymax_c;

  assign at_row_end = (pix_x_q == xmax_q);
  assign at_last    = at_row_end && (pix_y_q == ymax_q);
  assign pix_fire   = pix_valid && pix_ready;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (tri_valid) state_d = StSetup;
      StSetup:  state_d = box_empty ? StFinish : StScan;
      StScan:   if (pix_ready && at_last) state_d = StFinish;
      StFinish: state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  always_comb begin
    tri_ready = 1'b0;
    pix_valid = 1'b0;
    tri_done  = 1'b0;
    busy      = 1'b1;
    unique case (state_q)
      StIdle: begin
        tri_ready = 1'b1;
        busy      = 1'b0;
      end
      StScan:   pix_valid = 1'b1;
      StFinish: tri_done  = 1'b1;
      default: ;
    endcase
  end

  assign pix_last  = pix_valid && at_last;
  assign pix_x     = pix_x_q;
  assign pix_y     = pix_y_q;
  assign pix_color = color_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      x0_q    <= '0;
      y0_q    <= '0;
      x1_q    <= '0;
      y1_q    <= '0;
      x2_q    <= '0;
      y2_q    <= '0;
      color_q <= '0;
      xmin_q  <= '0;
      xmax_q  <= '0;
      ymax_q  <= '0;
      pix_x_q <= '0;
      pix_y_q <= '0;
    end else begin
      if (state_q == StIdle && tri_valid) begin
        x0_q    <= tri_x0;
        y0_q    <= tri_y0;
        x1_q    <= tri_x1;
        y1_q    <= tri_y1;
        x2_q    <= tri_x2;
        y2_q    <= tri_y2;
        color_q <= tri_color;
      end
      if (state_q == StSetup && !box_empty) begin
        xmin_q  <= xlo;
        xmax_q  <= xhi;
        ymax_q  <= yhi;
        pix_x_q <= xlo;
        pix_y_q <= ylo;
      end
      if (pix_fire && !at_last) begin
        if (at_row_end) begin
          pix_x_q <= xmin_q;
          pix_y_q <= pix_y_q + 1'b1;
        end else begin
          pix_x_q <= pix_x_q + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_tri_bbox_scanner.sv
// Directed bench for tri_bbox_scanner on a reduced 64x48 frame so full-frame scans stay short.
module tb_tri_bbox_scanner;

  localparam int FW = 64;
  localparam int FH = 48;
  localparam int CB = 16;

  logic                 clk;
  logic                 rst;
  logic                 tri_valid;
  logic                 tri_ready;
  logic signed [CB-1:0] tri_x0, tri_y0, tri_x1, tri_y1, tri_x2, tri_y2;
  logic [15:0]          tri_color;
  logic                 pix_valid;
  logic                 pix_ready;
  logic [CB-1:0]        pix_x, pix_y;
  logic [15:0]          pix_color;
  logic                 pix_last, tri_done, busy;

  int total = 0;
  int bad   = 0;

  logic [CB-1:0] qx[$];
  logic [CB-1:0] qy[$];
  logic [15:0]   qc[$];
  bit            ql[$];
  int            first_valid, last_hs, done_cyc, hold_err;
  bit            any_valid;

  tri_bbox_scanner #(
    .FRAME_WIDTH (FW),
    .FRAME_HEIGHT(FH),
    .COORD_BITS  (CB),
    .COLOR_BITS  (16)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .tri_valid(tri_valid),
    .tri_ready(tri_ready),
    .tri_x0   (tri_x0),
    .tri_y0   (tri_y0),
    .tri_x1   (tri_x1),
    .tri_y1   (tri_y1),
    .tri_x2   (tri_x2),
    .tri_y2   (tri_y2),
    .tri_color(tri_color),
    .pix_valid(pix_valid),
    .pix_ready(pix_ready),
    .pix_x    (pix_x),
    .pix_y    (pix_y),
    .pix_color(pix_color),
    .pix_last (pix_last),
    .tri_done (tri_done),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Presents a triangle and waits for the handshake; leaves tri_valid high when hold is set.
  task automatic offer_tri(input int x0, input int y0, input int x1, input int y1,
                           input int x2, input int y2, input logic [15:0] col,
                           input bit hold, output bit ok);
    tri_x0    = CB'(x0);
    tri_y0    = CB'(y0);
    tri_x1    = CB'(x1);
    tri_y1    = CB'(y1);
    tri_x2    = CB'(x2);
    tri_y2    = CB'(y2);
    tri_color = col;
    tri_valid = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (tri_ready) begin
        ok = 1'b1;
        break;
      end
      step();
    end
    step();
    if (!hold) tri_valid = 1'b0;
  endtask

  // Consumes pixels until tri_done; alt stalls every other cycle. Cycle 0 is the SETUP cycle.
  task automatic collect(input int max_cyc, input bit alt);
    logic [CB-1:0] hx, hy;
    logic [15:0]   hc;
    bit            hl, stalled;
    qx.delete();
    qy.delete();
    qc.delete();
    ql.delete();
    first_valid = -1;
    last_hs     = -1;
    done_cyc    = -1;
    hold_err    = 0;
    any_valid   = 1'b0;
    stalled     = 1'b0;
    hx = '0;
    hy = '0;
    hc = '0;
    hl = 1'b0;
    for (int c = 0; c < max_cyc; c++) begin
      if (stalled && (pix_valid !== 1'b1 || pix_x !== hx || pix_y !== hy ||
                      pix_color !== hc || pix_last !== hl)) hold_err++;
      if (tri_done === 1'b1) begin
        done_cyc = c;
        break;
      end
      pix_ready = alt ? (c % 2 == 1) : 1'b1;
      stalled   = 1'b0;
      if (pix_valid === 1'b1) begin
        any_valid = 1'b1;
        if (first_valid < 0) first_valid = c;
        if (pix_ready) begin
          qx.push_back(pix_x);
          qy.push_back(pix_y);
          qc.push_back(pix_color);
          ql.push_back(pix_last);
          last_hs = c;
        end else begin
          stalled = 1'b1;
          hx = pix_x;
          hy = pix_y;
          hc = pix_color;
          hl = pix_last;
        end
      end
      step();
    end
    pix_ready = 1'b1;
  endtask

  task automatic test_reset();
    rst       = 1'b0;
    tri_valid = 1'b0;
    pix_ready = 1'b1;
    step();
    step();
    total++;
    if (tri_ready !== 1'b1 || busy !== 1'b0) begin
      bad++;
      $display("FAIL reset_ready_busy: got ready=%b busy=%b want 1 0", tri_ready, busy);
    end
    total++;
    if (pix_valid !== 1'b0 || pix_last !== 1'b0 || tri_done !== 1'b0) begin
      bad++;
      $display("FAIL reset_flags: got valid=%b last=%b done=%b want 0 0 0",
               pix_valid, pix_last, tri_done);
    end
    total++;
    if (pix_x !== 16'd0 || pix_y !== 16'd0 || pix_color !== 16'd0) begin
      bad++;
      $display("FAIL reset_outputs: got x=%0d y=%0d c=%h want 0 0 0", pix_x, pix_y, pix_color);
    end
    rst = 1'b1;
    step();
  endtask

  task automatic test_basic();
    bit ok;
    int errs, idx, lerr, cerr;
    offer_tri(10, 20, 13, 20, 10, 22, 16'h0F00, 1'b0, ok);
    collect(100, 1'b0);
    total++;
    if (qx.size() !== 12) begin
      bad++;
      $display("FAIL basic_count: got %0d want 12", qx.size());
    end
    errs = 0;
    idx  = 0;
    for (int y = 20; y <= 22; y++) begin
      for (int x = 10; x <= 13; x++) begin
        if (idx >= qx.size() || qx[idx] !== CB'(x) || qy[idx] !== CB'(y)) errs++;
        idx++;
      end
    end
    total++;
    if (errs !== 0) begin
      bad++;
      $display("FAIL basic_order: got %0d wrong pixels want 0", errs);
    end
    lerr = 0;
    cerr = 0;
    for (int i = 0; i < qx.size(); i++) begin
      if (ql[i] !== (i == 11)) lerr++;
      if (qc[i] !== 16'h0F00) cerr++;
    end
    total++;
    if (lerr !== 0 || cerr !== 0) begin
      bad++;
      $display("FAIL basic_last_color: got last_err=%0d color_err=%0d want 0 0", lerr, cerr);
    end
    total++;
    if (first_valid !== 1) begin
      bad++;
      $display("FAIL basic_latency: got first valid at %0d want 1", first_valid);
    end
    total++;
    if (done_cyc !== 13 || done_cyc !== last_hs + 1) begin
      bad++;
      $display("FAIL basic_done: got done at %0d last handshake %0d want 13 12", done_cyc, last_hs);
    end
    step();
    total++;
    if (tri_ready !== 1'b1 || busy !== 1'b0) begin
      bad++;
      $display("FAIL basic_idle: got ready=%b busy=%b want 1 0", tri_ready, busy);
    end
  endtask

  task automatic test_clip();
    bit ok;
    int errs, idx;
    offer_tri(-5, -3, 600, 2, 0, 400, 16'h1234, 1'b0, ok);
    collect(FW * FH + 50, 1'b0);
    total++;
    if (qx.size() !== FW * FH) begin
      bad++;
      $display("FAIL clip_count: got %0d want %0d", qx.size(), FW * FH);
    end
    errs = 0;
    idx  = 0;
    for (int y = 0; y < FH; y++) begin
      for (int x = 0; x < FW; x++) begin
        if (idx >= qx.size() || qx[idx] !== CB'(x) || qy[idx] !== CB'(y) ||
            ql[idx] !== (idx == FW * FH - 1)) errs++;
        idx++;
      end
    end
    total++;
    if (errs !== 0) begin
      bad++;
      $display("FAIL clip_order: got %0d wrong pixels want 0", errs);
    end
    total++;
    if (qx.size() == 0 || qx[0] !== 16'd0 || qy[0] !== 16'd0) begin
      bad++;
      $display("FAIL clip_first: got size=%0d want first pixel (0,0)", qx.size());
    end
    step();
  endtask

  task automatic test_offscreen();
    bit ok;
    offer_tri(600, 10, 700, 20, 650, 30, 16'hAAAA, 1'b0, ok);
    collect(50, 1'b0);
    total++;
    if (any_valid !== 1'b0) begin
      bad++;
      $display("FAIL off_valid: got pix_valid seen=%b want 0", any_valid);
    end
    total++;
    if (done_cyc !== 1) begin
      bad++;
      $display("FAIL off_done: got done at %0d want 1", done_cyc);
    end
    step();
    total++;
    if (tri_ready !== 1'b1) begin
      bad++;
      $display("FAIL off_ready: got %b want 1", tri_ready);
    end
  endtask

  task automatic test_stall();
    bit ok;
    int errs;
    offer_tri(5, 5, 6, 6, 5, 6, 16'h00F0, 1'b0, ok);
    collect(60, 1'b1);
    total++;
    if (qx.size() !== 4) begin
      bad++;
      $display("FAIL stall_count: got %0d want 4", qx.size());
    end
    errs = 0;
    for (int i = 0; i < 4; i++) begin
      if (i >= qx.size() || qx[i] !== CB'(5 + i % 2) || qy[i] !== CB'(5 + i / 2)) errs++;
    end
    total++;
    if (errs !== 0) begin
      bad++;
      $display("FAIL stall_order: got %0d wrong pixels want 0", errs);
    end
    total++;
    if (hold_err !== 0) begin
      bad++;
      $display("FAIL stall_hold: got %0d changes during stall want 0", hold_err);
    end
    step();
  endtask

  task automatic test_point();
    bit ok;
    offer_tri(7, 7, 7, 7, 7, 7, 16'h0777, 1'b0, ok);
    collect(30, 1'b0);
    total++;
    if (qx.size() !== 1) begin
      bad++;
      $display("FAIL point_count: got %0d want 1", qx.size());
    end
    total++;
    if (qx.size() < 1 || qx[0] !== 16'd7 || qy[0] !== 16'd7 || ql[0] !== 1'b1) begin
      bad++;
      $display("FAIL point_pixel: got size=%0d want (7,7) with last", qx.size());
    end
    step();
  endtask

  task automatic test_back_to_back();
    bit ok;
    offer_tri(1, 1, 2, 1, 1, 1, 16'h0001, 1'b1, ok);
    tri_x0 = 16'sd3;
    tri_y0 = 16'sd4;
    tri_x1 = 16'sd3;
    tri_y1 = 16'sd4;
    tri_x2 = 16'sd4;
    tri_y2 = 16'sd4;
    tri_color = 16'h0002;
    collect(30, 1'b0);
    total++;
    if (qx.size() !== 2 || tri_ready !== 1'b0) begin
      bad++;
      $display("FAIL b2b_first: got count=%0d ready=%b want 2 0", qx.size(), tri_ready);
    end
    step();
    total++;
    if (tri_ready !== 1'b1) begin
      bad++;
      $display("FAIL b2b_accept: got ready=%b after done want 1", tri_ready);
    end
    step();
    tri_valid = 1'b0;
    total++;
    if (busy !== 1'b1) begin
      bad++;
      $display("FAIL b2b_busy: got %b want 1", busy);
    end
    collect(30, 1'b0);
    total++;
    if (qx.size() !== 2 || qx[0] !== 16'd3 || qy[0] !== 16'd4 || qc[0] !== 16'h0002) begin
      bad++;
      $display("FAIL b2b_second: got count=%0d want 2 starting at (3,4)", qx.size());
    end
    step();
  endtask

  task automatic test_mid_reset();
    bit ok, done_seen;
    offer_tri(20, 20, 23, 20, 20, 23, 16'h0F0F, 1'b0, ok);
    pix_ready = 1'b1;
    for (int i = 0; i < 4; i++) step();
    rst = 1'b0;
    step();
    total++;
    if (pix_valid !== 1'b0 || tri_ready !== 1'b1 || busy !== 1'b0 || tri_done !== 1'b0) begin
      bad++;
      $display("FAIL mreset_state: got valid=%b ready=%b busy=%b done=%b want 0 1 0 0",
               pix_valid, tri_ready, busy, tri_done);
    end
    rst = 1'b1;
    done_seen = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      if (tri_done !== 1'b0) done_seen = 1'b1;
    end
    total++;
    if (done_seen !== 1'b0) begin
      bad++;
      $display("FAIL mreset_nodone: got tri_done seen=%b want 0", done_seen);
    end
    offer_tri(30, 10, 31, 10, 30, 11, 16'h0ABC, 1'b0, ok);
    collect(30, 1'b0);
    total++;
    if (qx.size() !== 4 || qx[0] !== 16'd30 || qy[0] !== 16'd10 ||
        qx[3] !== 16'd31 || qy[3] !== 16'd11) begin
      bad++;
      $display("FAIL mreset_rescan: got count=%0d want 4 from (30,10) to (31,11)", qx.size());
    end
    step();
  endtask

  initial begin
    tri_valid = 1'b0;
    pix_ready = 1'b1;
    tri_x0    = '0;
    tri_y0    = '0;
    tri_x1    = '0;
    tri_y1    = '0;
    tri_x2    = '0;
    tri_y2    = '0;
    tri_color = '0;
    rst       = 1'b0;
    test_reset();
    test_basic();
    test_clip();
    test_offscreen();
    test_stall();
    test_point();
    test_back_to_back();
    test_mid_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
